// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and default widths for the I2S receiver.
//   i2s_rx_state_t   : receiver framing state
//   DEF_SAMPLE_WIDTH : serial bits captured per channel slot
//   DEF_OUT_WIDTH    : width of the parallel output sample
//   SCALE_W          : width of the left-shift scale control
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } i2s_rx_state_t;

  localparam int unsigned DEF_SAMPLE_WIDTH = 24;
  localparam int unsigned DEF_OUT_WIDTH    = 16;
  localparam int unsigned SCALE_W          = 3;
  localparam int unsigned SCALE_MAX        = (1 << SCALE_W) - 1;

endpackage

// File: rtl/i2s_receiver_sample_scaler.sv
// sample_scaler: combinational saturating left shift followed by truncation.
//   word     : signed SAMPLE_WIDTH input word
//   scale    : left-shift amount 0..SCALE_MAX
//   scaled_c : top OUT_WIDTH bits of the saturated, shifted word
module sample_scaler
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned OUT_WIDTH    = DEF_OUT_WIDTH
) (
  input  logic [SAMPLE_WIDTH-1:0] word,
  input  logic [SCALE_W-1:0]      scale,
  output logic [OUT_WIDTH-1:0]    scaled_c
);

  localparam int unsigned EXT_W = SAMPLE_WIDTH + SCALE_MAX;
  localparam int unsigned HI_W  = SCALE_MAX + 1;

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] shifted;
  logic [HI_W-1:0]  hi;
  logic             fits;
  logic             unused_low;

  // Sign-extend far enough that the largest shift can never lose bits.
  assign ext     = {{SCALE_MAX{word[SAMPLE_WIDTH-1]}}, word};
  assign shifted = ext << scale;

  // The result fits the signed SAMPLE_WIDTH range when every bit from the
  // sign position upward is a copy of the sign.
  assign hi   = shifted[EXT_W-1:SAMPLE_WIDTH-1];
  assign fits = (hi == '0) || (hi == '1);

  always_comb begin
    scaled_c = shifted[SAMPLE_WIDTH-1 -: OUT_WIDTH];
    if (!fits) begin
      if (shifted[EXT_W-1]) scaled_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                  scaled_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  // Low bits are dropped by the truncation.
  assign unused_low = ^shifted;

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: deserialises the I2S ADC bitstream into signed, scaled
// parallel samples presented as a one-cycle valid pulse. sclk and lrck are
// levels sampled in the clk domain, never used as clocks.
//   clk, reset  : system clock, asynchronous active-high reset
//   sclk        : serial bit clock level
//   lrck        : word select level (0 = left, 1 = right)
//   adc         : serial data, MSB first, one bit after the lrck change
//   adcScale    : left-shift amount applied before output
//   sampleData  : registered scaled sample
//   sampleValid : one-cycle pulse marking new sampleData
//   sampleRight : channel of sampleData (only with I2S_RX_STEREO_EN)
// Macro I2S_RX_STEREO_EN: capture both channels; otherwise left only.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int unsigned OUT_WIDTH    = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 lrck,
  input  logic                 adc,
  input  logic [SCALE_W-1:0]   adcScale,
  output logic [OUT_WIDTH-1:0] sampleData,
  output logic                 sampleValid
`ifdef I2S_RX_STEREO_EN
  ,
  output logic                 sampleRight
`endif
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH + 1);

  i2s_rx_state_t             state;
  logic                      sclk_prev;
  logic                      lrck_prev;
  logic [SAMPLE_WIDTH-2:0]   shreg;
  logic [CNT_W-1:0]          cnt;
  logic [SAMPLE_WIDTH-1:0]   word_q;
  logic [SCALE_W-1:0]        scale_q;
  logic                      pend;
  logic [SAMPLE_WIDTH-1:0]   shift_in;
  logic [OUT_WIDTH-1:0]      scaled;
  logic                      rise;
  logic                      chg;
  logic                      arm_ok;
  logic                      last_bit;
`ifdef I2S_RX_STEREO_EN
  logic                      slot_right;
  logic                      word_right;
`endif

  assign rise     = sclk & ~sclk_prev;
  assign chg      = lrck ^ lrck_prev;
  assign shift_in = {shreg, adc};
  assign last_bit = (cnt == CNT_W'(SAMPLE_WIDTH - 1));

  // Whether a channel change into the current lrck level opens a capture slot.
`ifdef I2S_RX_STEREO_EN
  assign arm_ok = 1'b1;
`else
  assign arm_ok = ~lrck;
`endif

  sample_scaler #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_scaler (
    .word     (word_q),
    .scale    (scale_q),
    .scaled_c (scaled)
  );

  // Framing FSM, shift register and output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      sclk_prev   <= 1'b0;
      lrck_prev   <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      word_q      <= '0;
      scale_q     <= '0;
      pend        <= 1'b0;
      sampleData  <= '0;
      sampleValid <= 1'b0;
`ifdef I2S_RX_STEREO_EN
      slot_right  <= 1'b0;
      word_right  <= 1'b0;
      sampleRight <= 1'b0;
`endif
    end else begin
      sclk_prev   <= sclk;
      pend        <= 1'b0;
      sampleValid <= pend;

      // Word latched on the previous cycle goes out scaled on this one.
      if (pend) begin
        sampleData  <= scaled;
`ifdef I2S_RX_STEREO_EN
        sampleRight <= word_right;
`endif
      end

      if (rise) begin
        lrck_prev <= lrck;
        case (state)
          SYNC: begin
            // Frame alignment: only a right-to-left change starts capture.
            if (chg && !lrck) state <= ARMED;
          end
          ARMED: begin
            shreg <= shift_in[SAMPLE_WIDTH-2:0];
            cnt   <= CNT_W'(1);
`ifdef I2S_RX_STEREO_EN
            slot_right <= lrck;
`endif
            state <= SHIFT;
          end
          SHIFT: begin
            shreg <= shift_in[SAMPLE_WIDTH-2:0];
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
              // Final bit wins over a coincident channel change.
              word_q  <= shift_in;
              scale_q <= adcScale;
              pend    <= 1'b1;
`ifdef I2S_RX_STEREO_EN
              word_right <= slot_right;
`endif
              state <= (chg && arm_ok) ? ARMED : WAIT;
            end else if (chg) begin
              // Short slot: drop the partial word.
              state <= arm_ok ? ARMED : WAIT;
            end
          end
          WAIT: begin
            if (chg && arm_ok) state <= ARMED;
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: randomized scoreboard bench for i2s_receiver. Slots are
// driven at the frame level; the reference model decides from slot length,
// channel and sync history whether a sample is due, and computes its value
// with integer arithmetic. A monitor pops expectations on every valid.
// Honours I2S_RX_STEREO_EN to match the DUT build.
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int unsigned SW = 24;
  localparam int unsigned OW = 16;
`ifdef I2S_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sclk;
  logic          lrck;
  logic          adc;
  logic [2:0]    adcScale;
  logic [OW-1:0] sampleData;
  logic          sampleValid;
`ifdef I2S_RX_STEREO_EN
  logic          sampleRight;
`endif

  typedef struct {
    logic [OW-1:0] data;
    logic          right;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  logic prev_valid = 1'b0;

  // Frame-level model state.
  logic prev_ch;
  logic synced;
  logic carry;

  i2s_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .lrck        (lrck),
    .adc         (adc),
    .adcScale    (adcScale),
    .sampleData  (sampleData),
    .sampleValid (sampleValid)
`ifdef I2S_RX_STEREO_EN
    ,
    .sampleRight (sampleRight)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference scaling: signed value times 2^scale, clamp, keep top OW bits.
  function automatic logic [OW-1:0] ref_scale(input logic [SW-1:0] w, input logic [2:0] s);
    longint v;
    longint lo;
    longint hi;
    v  = longint'(w);
    if (w[SW-1]) v = v - (longint'(1) <<< SW);
    v  = v * (longint'(1) <<< s);
    hi = (longint'(1) <<< (SW - 1)) - 1;
    lo = -(longint'(1) <<< (SW - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    v = v >>> (SW - OW);
    return OW'(v);
  endfunction

  task automatic send_bit(input logic l, input logic d);
    @(negedge clk);
    sclk = 1'b0;
    lrck = l;
    adc  = d;
    @(negedge clk);
    @(negedge clk);
    sclk = 1'b1;
    @(negedge clk);
  endtask

  // One channel slot of len bit periods; bit 0 carries the previous word's
  // delayed LSB slot position, bits 1..SW carry w MSB first. A slot of
  // exactly SW periods leaves w's LSB to the next slot's first bit.
  task automatic send_slot(input logic ch, input int len,
                           input logic [SW-1:0] w, input logic [2:0] sc);
    logic trans;
    logic d;
    trans = (ch != prev_ch);
    if (trans && !ch) synced = 1'b1;
    if (synced && trans && len >= int'(SW) && (STEREO || !ch))
      q.push_back('{ref_scale(w, sc), ch});
    for (int i = 0; i < len; i++) begin
      if (i == 0)              d = carry;
      else if (i <= int'(SW))  d = w[SW-i];
      else                     d = 1'($urandom_range(0, 1));
      if (i == 1) adcScale = sc;
      send_bit(ch, d);
    end
    carry   = (len == int'(SW)) ? w[0] : 1'($urandom_range(0, 1));
    prev_ch = ch;
  endtask

  task automatic model_reset();
    prev_ch = 1'b0;
    synced  = 1'b0;
    carry   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (sampleData === '0) passes++;
    else $display("FAIL %s_data: got %h, want 0", tag, sampleData);
    checks++;
    if (sampleValid === 1'b0) passes++;
    else $display("FAIL %s_valid: got %b, want 0", tag, sampleValid);
`ifdef I2S_RX_STEREO_EN
    checks++;
    if (sampleRight === 1'b0) passes++;
    else $display("FAIL %s_right: got %b, want 0", tag, sampleRight);
`endif
  endtask

  // Monitor: compare every valid against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && sampleValid === 1'b1) begin
      checks++;
      if (!prev_valid) passes++;
      else $display("FAIL valid_pulse: valid high on consecutive cycles");
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: data %h with no expected sample", sampleData);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (sampleData === mon_e.data) passes++;
        else $display("FAIL sample_data: got %h, want %h", sampleData, mon_e.data);
`ifdef I2S_RX_STEREO_EN
        checks++;
        if (sampleRight === mon_e.right) passes++;
        else $display("FAIL sample_right: got %b, want %b", sampleRight, mon_e.right);
`endif
      end
    end
    prev_valid = (!reset && sampleValid === 1'b1);
  end

  logic [SW-1:0] rw;
  int            rl;
  int            lens[5] = '{32, 32, 24, 11, 28};

  initial begin
    reset    = 1'b1;
    sclk     = 1'b0;
    lrck     = 1'b0;
    adc      = 1'b0;
    adcScale = 3'd0;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs("init");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Directed: frame begins in the right slot; then the listed words.
    send_slot(1'b1, 32, 24'h777777, 3'd0);
    send_slot(1'b0, 32, 24'h123456, 3'd0);
    send_slot(1'b1, 32, 24'h222222, 3'd0);
    send_slot(1'b0, 32, 24'hFEDCBA, 3'd1);
    send_slot(1'b1, 32, 24'h0F0F0F, 3'd3);
    send_slot(1'b0, 32, 24'h400000, 3'd2);
    send_slot(1'b1, 32, 24'h800001, 3'd2);
    send_slot(1'b0, 32, 24'hA00000, 3'd1);
    send_slot(1'b1, 32, 24'h7FFFFF, 3'd0);
    // Short left slot, then a full word.
    send_slot(1'b0, 11, 24'h5A5A5A, 3'd0);
    send_slot(1'b1, 32, 24'h333333, 3'd0);
    send_slot(1'b0, 32, 24'h000100, 3'd0);
    send_slot(1'b1, 32, 24'h444444, 3'd0);
    send_slot(1'b0, 32, 24'h111111, 3'd0);
    send_slot(1'b1, 32, 24'h222222, 3'd0);
    // Final bit coincides with the channel change.
    send_slot(1'b0, 24, 24'hC3A5E7, 3'd1);
    send_slot(1'b1, 24, 24'h3C5A7E, 3'd2);
    send_slot(1'b0, 32, 24'h0000FF, 3'd7);
    send_slot(1'b1, 32, 24'hFFFF00, 3'd7);

    // Randomized slots.
    for (int k = 0; k < 24; k++) begin
      rw = SW'($urandom);
      rl = lens[$urandom_range(0, 4)];
      send_slot(1'(k & 1), rl, rw, 3'($urandom_range(0, 7)));
    end
    if (prev_ch == 1'b0) send_slot(1'b1, 32, SW'($urandom), 3'd0);

    // Reset in the middle of a left word.
    send_slot(1'b0, 32, 24'h123456, 3'd0);
    send_slot(1'b1, 32, 24'h654321, 3'd0);
    send_slot(1'b0, 13, 24'h0ABCDE, 3'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midword_reset");
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    send_slot(1'b0, 20, 24'h999999, 3'd0);
    send_slot(1'b1, 32, 24'h246802, 3'd0);
    send_slot(1'b0, 32, 24'h135790, 3'd1);
    send_slot(1'b1, 32, 24'hBEEF01, 3'd0);
    send_slot(1'b0, 32, 24'h000000, 3'd0);

    repeat (40) @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected samples never appeared", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Receiver stage ahead of the FIR engine. It deserializes the I2S2 ADC bitstream into signed parallel samples and scales them with a saturating shift. It then hands each sample to the filter as a one-cycle valid pulse. The block runs entirely in the system clock domain: `sclk` and `lrck` are the internally generated clock-enable levels, never used as clocks.

## Interface
- `SAMPLE_WIDTH`, 24: serial bits captured per channel slot, MSB first.
- `OUT_WIDTH`, 16: width of `sampleData`; must be ≤ `SAMPLE_WIDTH`.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `sclk` input 1: serial bit clock level, synchronous to `clk`, high/low phases ≥2 `clk` cycles each.
- `lrck` input 1: word select level, synchronous to `clk`; low = left, high = right.
- `adc` input 1: serial data from the ADC.
- `adcScale` input 3: left-shift amount 0–7 applied before output.
- `sampleData` output `OUT_WIDTH`: signed scaled sample.
- `sampleValid` output 1: one-cycle pulse marking a new `sampleData`.
- `sampleRight` output 1: channel of the current sample. Present only with `I2S_RX_STEREO_EN`.

## Operation
- Rise detect: `sclkPrev` is registered from `sclk`; `rise = sclk & ~sclkPrev`. All sampling of `adc` and `lrck` happens only in cycles where `rise` is true.
- Channel change: on a rise where sampled `lrck` differs from `lrckPrev` (updated on every rise).
- States:
  - `SYNC` (reset state): wait for a high→low channel change, then go to `ARMED`.
  - `ARMED`: the next rise carries the MSB (I2S one-bit delay). On that rise, shift in `adc`, clear the bit counter to 1, and go to `SHIFT`.
  - `SHIFT`: shift `adc` in on each rise. When the counter reaches `SAMPLE_WIDTH`, latch the word and go to `WAIT`.
  - `WAIT`: ignore the remaining slot bits. On a channel change, go to `ARMED`.
- Channel gating: without the macro, a channel change to high (right) leads to `WAIT`, not `ARMED`. The right slot is never captured.
- Short slot: a channel change while in `SHIFT` discards the partial word, emits no valid, and goes to `ARMED` (or `WAIT` for an ignored channel).
- Scaling arithmetic:
  - The word is treated as signed `SAMPLE_WIDTH`.
  - It is shifted left by `adcScale`, computed in `SAMPLE_WIDTH+7` bits.
  - It saturates to signed `SAMPLE_WIDTH` range: max 0x7FFFFF, min 0x800000 for 24.
  - `sampleData` is the top `OUT_WIDTH` bits (truncation, no rounding).
- Reset values: `sampleData` = 0, `sampleValid` = 0, `sampleRight` = 0, state `SYNC`, shift register and counter 0.

## Timing
- Cycle N: the clock edge where the `SAMPLE_WIDTH`-th bit is shifted in. `adcScale` is sampled at cycle N.
- Cycle N+1: `sampleData` is updated and `sampleValid` is high for exactly one cycle.
- `sampleData` holds its value until the next valid.
- Reset mid-word: output regs clear immediately (asynchronous). After release, the block resynchronises via `SYNC`; the first valid comes only after a full left slot.
- Simultaneous channel change and final bit on the same rise: the final bit completes the word and is emitted; the change then arms the next slot.

## Configuration
- `I2S_RX_STEREO_EN` defined:
  - Both channels are captured. A low→high change also arms.
  - `sampleRight` is present and registered with `sampleData`: 0 for left, 1 for right.
  - Valids alternate L, R.
- Macro undefined:
  - Left channel only.
  - The `sampleRight` port and its logic are removed.

## Structure
- Package `i2s_pkg`:
  - state enum `i2s_rx_state_t` (`SYNC`, `ARMED`, `SHIFT`, `WAIT`);
  - default width constants;
  - scale-width constant (3).
- Sub-module `sample_scaler`: combinational saturating shift-and-truncate (`SAMPLE_WIDTH`, `OUT_WIDTH` parameters), instantiated once ahead of the output register.

## Test plan
- Left word 0x123456, scale 0, defaults → `sampleData` = 0x1234, one valid pulse, no valid for the right slot.
- Left word 0xFEDCBA, scale 1 → 0xFDB9; left word 0x400000, scale 2 → 0x7FFF (saturated); 0xA00000, scale 1 → 0x8000.
- Channel change after 10 bits of a left slot → no valid. The following full left word 0x000100 at scale 0 → 0x0001.
- Reset asserted after 12 bits → outputs 0 immediately. After release, the first valid appears only after the next complete left slot.
- Frame starting in the right slot after reset → right data ignored, first valid from the left word.
- With `I2S_RX_STEREO_EN`: L = 0x111111, R = 0x222222 → valids 0x1111 with `sampleRight`=0, then 0x2222 with `sampleRight`=1.
